sig_scalar_unpack: RTL and testbench
====================================

# sig_scalar_unpack

Verifier-side receive path for Ed25519 signatures. It accepts a 64-byte signature over a byte-wide valid/ready stream, little-endian, R first then S. It unpacks the signature into the 256-bit R point encoding and the S scalar, and checks during transfer that S is canonical (S < L). It is the consumer of the scalar produced by the signing-side `(r + k·s) mod L` arithmetic and feeds the verification datapath.

## Interface
- Parameters: none. L = 2^252 + 0x14def9dea2f79cd65812631a5cf5d3ed is a fixed localparam. Its bytes LSB-first are: ed d3 f5 5c 1a 63 12 58 d6 9c f7 a2 de f9 de 14, then 15×00, then 10.
- clk  input  1  single clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  begins one signature reception; sampled only in IDLE.
- in_data  input  8  signature byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts a byte; a transfer occurs on an edge with in_valid && in_ready.
- r_out  output  256  R encoding; byte i of the stream goes to r_out[8i+7:8i], i = 0..31.
- s_out  output  253  S[252:0]; stream byte 32+j goes to S[8j+7:8j].
- s_canonical  output  1  1 iff the full 256-bit S < L.
- done  output  1  one-cycle pulse; outputs are valid.
- busy  output  1  high whenever state != IDLE.

## Operation
- States: IDLE, LOAD_R, LOAD_S, CHECK.
- IDLE:
  - in_ready = 0.
  - On start: clear byte counter, lt flag and S[255:253] shadow bits. r_out and s_out are not cleared. Go to LOAD_R.
- LOAD_R:
  - in_ready = 1.
  - Each transfer writes r_out byte cnt and increments cnt.
  - After byte 31: cnt ← 0, go to LOAD_S.
- LOAD_S:
  - in_ready = 1.
  - Each transfer writes S byte cnt. For cnt = 31, bits [4:0] go to s_out[252:248] and bits [7:5] go to the shadow bits.
  - Running compare against L byte Lb[cnt], LSB-first: lt ← (b < Lb) | ((b == Lb) & lt). The initial lt is 0, so S == L gives lt = 0.
  - After byte 31, go to CHECK.
- CHECK (one cycle): s_canonical ← lt, done ← 1, go to IDLE.
  - The byte-serial compare already covers the shadow bits; no separate test of them is required.
- done is high for exactly one cycle. It is cleared in every other state.
- r_out, s_out and s_canonical hold from the done cycle until the next accepted start. They are not cleared by start; they may change while loading.
- start while busy is ignored. start in the same cycle as done (state returned to IDLE) is accepted on the following edge only if still asserted.
- in_valid while in_ready = 0 is ignored; no byte is consumed.
- cnt is a 5-bit counter; the wrap at 31 → 0 is the R/S boundary, not an error.

## Timing
- Reset (rst = 0 at an edge):
  - state = IDLE; in_ready = 0, done = 0, busy = 0, s_canonical = 0, r_out = 0, s_out = 0, cnt = 0, lt = 0.
  - Reset takes priority over every other input, including mid-transfer. A partial signature is discarded, and no done pulse is produced for it.
- Latency: E0 is the edge sampling start.
  - busy and in_ready are high after E0.
  - With in_valid held high, bytes transfer on E1..E64, and the state is CHECK after E64.
  - done and s_canonical update at E65; done falls at E66.
- Stalls: each cycle with in_valid = 0 in LOAD_R/LOAD_S adds exactly one cycle of latency. State and cnt are held.
- No combinational path from in_valid to in_ready; in_ready is a function of state only.

## Test plan
- Zero S: R = 00..1f (byte i = i), S = all 0x00, back-to-back → r_out = 0x1f1e…0100, s_out = 0, s_canonical = 1, done at E65, single pulse.
- S = L−1 (first byte ec, rest as L) → s_canonical = 1, s_out = L−1. S = L → s_canonical = 0, s_out = L.
- S = 2^253 (last byte 0x20, rest 0) → s_canonical = 0, s_out = 0. S = all 0xFF → s_canonical = 0.
- Stalls: drop in_valid for 3 cycles after byte 10 and 5 cycles after byte 40 → identical outputs, done at E73.
- Reset mid-operation: assert rst after byte 20 of R, then run a full S = 1 signature → no done until the second run, which gives s_canonical = 1 with correct r_out.
- start pulsed during LOAD_S → ignored: one done only, cnt sequence unaffected, busy stays high until E65.

Source files
------------

// File: rtl/sig_scalar_unpack.sv
// Ed25519 signature receive path: unpacks R and S from a byte stream
// and checks during the transfer that S is below the group order L.
module sig_scalar_unpack (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [255:0] r_out,
    output logic [252:0] s_out,
    output logic         s_canonical,
    output logic         done,
    output logic         busy
);

    localparam logic [255:0] L_VAL =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef enum logic [1:0] {IDLE, LOAD_R, LOAD_S, CHECK} state_t;

    state_t         state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           lt_q, lt_d;
    logic [2:0]     sh_q, sh_d;
    logic [255:0]   r_q, r_d;
    logic [252:0]   s_q, s_d;
    logic           canon_q, canon_d;
    logic           done_q, done_d;
    logic [255:0]   s_wide;
    logic [7:0]     lb;
    logic           xfer;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= 5'd0;
            lt_q    <= 1'b0;
            sh_q    <= 3'd0;
            r_q     <= '0;
            s_q     <= '0;
            canon_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            sh_q    <= sh_d;
            r_q     <= r_d;
            s_q     <= s_d;
            canon_q <= canon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD_R;
            LOAD_R:  if (xfer && cnt_q == 5'd31) state_d = LOAD_S;
            LOAD_S:  if (xfer && cnt_q == 5'd31) state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == LOAD_R) || (state_q == LOAD_S);
        busy     = (state_q != IDLE);
        xfer     = in_valid && in_ready;
    end

    // The 5-bit counter wraps 31 -> 0 at the R/S boundary by design.
    always_comb begin
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        sh_d    = sh_q;
        r_d     = r_q;
        s_d     = s_q;
        canon_d = canon_q;
        done_d  = 1'b0;
        s_wide  = {sh_q, s_q};
        lb      = L_VAL[{cnt_q, 3'b000} +: 8];
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d = 5'd0;
                    lt_d  = 1'b0;
                    sh_d  = 3'd0;
                end
            end
            LOAD_R: begin
                if (xfer) begin
                    r_d[{cnt_q, 3'b000} +: 8] = in_data;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            LOAD_S: begin
                if (xfer) begin
                    s_wide[{cnt_q, 3'b000} +: 8] = in_data;
                    s_d   = s_wide[252:0];
                    sh_d  = s_wide[255:253];
                    lt_d  = (in_data < lb) | ((in_data == lb) & lt_q);
                    cnt_d = cnt_q + 5'd1;
                end
            end
            CHECK: begin
                // Shadow bits set imply S >= 2^253 > L; lt is already 0 then.
                canon_d = lt_q & (sh_q == 3'd0);
                done_d  = 1'b1;
            end
            default: ;
        endcase
    end

    assign r_out       = r_q;
    assign s_out       = s_q;
    assign s_canonical = canon_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sig_scalar_unpack.sv
// Directed bench for sig_scalar_unpack with a scoreboard of expected
// signature fields, checked when the done pulse appears.
module tb_sig_scalar_unpack;

    localparam logic [255:0] L_VAL =
        256'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed;

    typedef struct {
        logic [255:0] r;
        logic [252:0] s;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] r_out;
    logic [252:0] s_out;
    logic         s_canonical;
    logic         done;
    logic         busy;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    sig_scalar_unpack dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .r_out       (r_out),
        .s_out       (s_out),
        .s_canonical (s_canonical),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_sig(input logic [511:0] sig,
                           input int st_a, input int len_a,
                           input int st_b, input int len_b,
                           input int start_at, input bit idle_junk,
                           input int exp_lat);
        exp_t e;
        int ecnt;
        int busy_low;
        bit seen;
        e.r = sig[255:0];
        e.s = sig[508:256];
        e.c = (sig[511:256] < L_VAL);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        in_valid = idle_junk;
        in_data = 8'h5a;
        @(negedge clk);
        start = 1'b0;
        ecnt = 0;
        busy_low = 0;
        chk("busy_e0", 256'(busy), 256'(1));
        chk("ready_e0", 256'(in_ready), 256'(1));
        for (int k = 0; k < 64; k++) begin
            in_data = sig[8*k +: 8];
            in_valid = 1'b1;
            start = (k == start_at);
            @(negedge clk);
            ecnt++;
            if (!busy) busy_low++;
            start = 1'b0;
            if (k == st_a) begin
                in_valid = 1'b0;
                repeat (len_a) begin
                    @(negedge clk);
                    ecnt++;
                    if (!busy) busy_low++;
                end
            end
            if (k == st_b) begin
                in_valid = 1'b0;
                repeat (len_b) begin
                    @(negedge clk);
                    ecnt++;
                    if (!busy) busy_low++;
                end
            end
        end
        in_valid = 1'b0;
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            ecnt++;
            if (done) seen = 1'b1;
            else if (!busy) busy_low++;
        end
        chk("done_lat", 256'(ecnt), 256'(exp_lat));
        chk("busy_gap", 256'(busy_low), 256'(0));
        e = sb.pop_front();
        chk("r_out", r_out, e.r);
        chk("s_out", 256'(s_out), 256'(e.s));
        chk("s_canonical", 256'(s_canonical), 256'(e.c));
        @(negedge clk);
        chk("done_fall", 256'(done), 256'(0));
        chk("busy_idle", 256'(busy), 256'(0));
        chk("r_hold", r_out, e.r);
        chk("canon_hold", 256'(s_canonical), 256'(e.c));
    endtask

    initial begin
        logic [255:0] r_inc;
        logic [255:0] r_alt;
        logic [255:0] s_rnd;

        rst = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(in_ready), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_canon", 256'(s_canonical), 256'(0));
        chk("rst_r", r_out, 256'(0));
        chk("rst_s", 256'(s_out), 256'(0));
        rst = 1'b1;

        for (int i = 0; i < 32; i++) begin
            r_inc[8*i +: 8] = 8'(i);
            r_alt[8*i +: 8] = 8'(8'ha0 ^ 8'(i));
        end

        run_sig({256'd0, r_inc}, -1, 0, -1, 0, -1, 1'b1, 65);
        chk("r_zero_s", r_out,
            256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100);

        run_sig({L_VAL - 256'd1, r_alt}, -1, 0, -1, 0, -1, 1'b0, 65);
        run_sig({L_VAL, r_alt}, -1, 0, -1, 0, -1, 1'b0, 65);
        run_sig({256'd1 << 253, r_inc}, -1, 0, -1, 0, -1, 1'b0, 65);
        run_sig({{256{1'b1}}, r_alt}, -1, 0, -1, 0, -1, 1'b0, 65);
        run_sig({256'd0, r_inc}, 10, 3, 40, 5, -1, 1'b0, 73);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            in_data = 8'(k);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_ready", 256'(in_ready), 256'(0));
        chk("mid_rst_r", r_out, 256'(0));
        repeat (3) @(negedge clk);
        chk("mid_rst_done", 256'(done), 256'(0));
        run_sig({256'd1, r_alt}, -1, 0, -1, 0, -1, 1'b0, 65);

        for (int i = 0; i < 8; i++) s_rnd[32*i +: 32] = $urandom;
        s_rnd[255:253] = 3'b000;
        s_rnd[252] = 1'b0;
        run_sig({s_rnd, r_inc}, -1, 0, -1, 0, 45, 1'b0, 65);
        repeat (3) @(negedge clk);
        chk("no_extra_done", 256'(done), 256'(0));

        chk("sb_empty", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
